// File: rtl/alu_rr_arbiter_pkg.sv
// rtl/alu_rr_arbiter_pkg.sv - shared FSM state encoding and port indices for alu_rr_arbiter
package alu_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/nbit_ALU.sv
// rtl/nbit_ALU.sv - n-bit ALU with (n+1)-bit result; MSB carries carry/borrow/shift-out
module nbit_ALU #(
  parameter int n = 8
) (
  input  logic [2:0]   sel,
  input  logic [n-1:0] r2,
  input  logic [n-1:0] r3,
  input  logic         cin,
  output logic [n:0]   out
);

  logic [n:0] a_ext;
  logic [n:0] b_ext;
  logic [n:0] c_ext;

  assign a_ext = {1'b0, r2};
  assign b_ext = {1'b0, r3};
  assign c_ext = {{n{1'b0}}, cin};

  always_comb begin
    out = '0;
    case (sel)
      3'b000:  out = a_ext + b_ext + c_ext;
      3'b001:  out = a_ext - b_ext - c_ext;
      3'b010:  out = {1'b0, r2 & r3};
      3'b011:  out = {1'b0, r2 | r3};
      3'b100:  out = {1'b0, r2 ^ r3};
      3'b101:  out = {1'b0, ~r2};
      3'b110:  out = {r2, cin};
      default: out = a_ext;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin req/ack arbiter sharing one nbit_ALU between two ports
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [2:0]   sel0,
  input  logic [n-1:0] a0,
  input  logic [n-1:0] b0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [2:0]   sel1,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] b1,
  input  logic         cin1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         ack0,
  output logic         ack1,
  output logic [n:0]   result,
  output logic         busy
);

  state_t       state;
  state_t       next_state;
  logic         owner;
  logic         rr;
  logic         win;
  logic         grant;
  logic [2:0]   sel_q;
  logic [n-1:0] a_q;
  logic [n-1:0] b_q;
  logic         cin_q;
  logic [n:0]   alu_out;
  logic [n:0]   result_q;

  // The ALU only ever sees captured operands, so requesters may change inputs after grant.
  nbit_ALU #(.n(n)) u_alu (
    .sel (sel_q),
    .r2  (a_q),
    .r3  (b_q),
    .cin (cin_q),
    .out (alu_out)
  );

  assign grant = (state == IDLE) && (req0 || req1);

  always_comb begin
    win = PORT0;
    if (req0 && req1) begin
      win = rr;
    end else if (req1) begin
      win = PORT1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= PORT0;
      rr       <= PORT0;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (grant) begin
        owner <= win;
        rr    <= ~win;
        if (win == PORT1) begin
          sel_q <= sel1;
          a_q   <= a1;
          b_q   <= b1;
          cin_q <= cin1;
        end else begin
          sel_q <= sel0;
          a_q   <= a0;
          b_q   <= b0;
          cin_q <= cin0;
        end
      end
      if (state == EXEC) begin
        result_q <= alu_out;
      end
    end
  end

  // Outputs decode flopped state only; req never reaches an output combinationally.
  always_comb begin
    busy   = (state == EXEC) || (state == RESP);
    gnt0   = busy && (owner == PORT0);
    gnt1   = busy && (owner == PORT1);
    ack0   = (state == RESP) && (owner == PORT0);
    ack1   = (state == RESP) && (owner == PORT1);
    result = result_q;
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - self-checking bench for alu_rr_arbiter against a cycle-level reference model
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] sel0 = '0, sel1 = '0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       cin0 = 1'b0, cin1 = 1'b0;
  logic       gnt0, gnt1, ack0, ack1, busy;
  logic [8:0] result;
  logic [13:0] obs;

  int checks = 0;
  int failures = 0;

  int m_phase = 0, m_owner = 0, m_ptr = 0, m_result = 0;
  int m_sel = 0, m_a = 0, m_b = 0, m_cin = 0;

  alu_rr_arbiter #(.n(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .sel0(sel0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .sel1(sel1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {gnt0, gnt1, ack0, ack1, busy, result};

  function automatic int alu_ref(int s, int a, int b, int c);
    case (s)
      0: return (a + b + c) % 512;
      1: return (512 + a - b - c) % 512;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return a * 2 + c;
      default: return a;
    endcase
  endfunction

  // Phase counts cycles since grant: 1 = executing, 2 = responding.
  task automatic model_step();
    int w;
    if (rst) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_result = 0;
    end else if (m_phase == 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
        if (w == 1) begin
          m_sel = int'(sel1); m_a = int'(a1); m_b = int'(b1); m_cin = int'(cin1);
        end else begin
          m_sel = int'(sel0); m_a = int'(a0); m_b = int'(b0); m_cin = int'(cin0);
        end
        m_owner = w;
        m_ptr = 1 - w;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_result = alu_ref(m_sel, m_a, m_b, m_cin);
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic bz;
    bz = (m_phase != 0);
    return {bz && m_owner == 0, bz && m_owner == 1,
            m_phase == 2 && m_owner == 0, m_phase == 2 && m_owner == 1,
            bz, 9'(m_result)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic rand_port0();
    sel0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom_range(0, 255));
    b0 = 8'($urandom_range(0, 255)); cin0 = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_port1();
    sel1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255)); cin1 = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== 14'h0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d obs=%h exp=%h", i, obs, 14'h0);
      end
    end
  endtask

  task automatic test_single();
    int acks = 0, ack_cyc = -1;
    sel0 = 3'b000; a0 = 8'h0F; b0 = 8'h01; cin0 = 1'b0;
    req0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL single cyc%0d obs=%h exp=%h", c, obs, exp_vec());
      end
      if (c == 1) begin
        checks++;
        if (gnt0 !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL single_gnt gnt0=%b busy=%b exp=1", gnt0, busy);
        end
      end
      if (ack0) begin
        acks++; ack_cyc = c;
        checks++;
        if (result !== 9'h010) begin
          failures++;
          $display("FAIL single_result obs=%h exp=%h", result, 9'h010);
        end
        req0 = 1'b0;
      end
    end
    checks++;
    if (acks != 1 || ack_cyc != 2) begin
      failures++;
      $display("FAIL single_ack count=%0d cyc=%0d exp count=1 cyc=2", acks, ack_cyc);
    end
  endtask

  task automatic test_tie();
    int ports[$];
    int cycs[$];
    do_reset();
    rand_port0(); rand_port1();
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL tie cyc%0d obs=%h exp=%h", c, obs, exp_vec());
      end
      if (ack0) begin ports.push_back(0); cycs.push_back(c); rand_port0(); end
      if (ack1) begin ports.push_back(1); cycs.push_back(c); rand_port1(); end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (ports.size() != 4) begin
      failures++;
      $display("FAIL tie_count obs=%0d exp=4", ports.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ports[k] != k % 2 || cycs[k] != 2 + 3 * k) begin
          failures++;
          $display("FAIL tie_order k=%0d port=%0d cyc=%0d exp port=%0d cyc=%0d",
                   k, ports[k], cycs[k], k % 2, 2 + 3 * k);
        end
      end
    end
    tick(); tick(); tick();
  endtask

  task automatic test_isolation();
    int exp_r;
    bit changed = 0, seen = 0;
    do_reset();
    rand_port1();
    exp_r = alu_ref(int'(sel1), int'(a1), int'(b1), int'(cin1));
    req1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL isolation cyc%0d obs=%h exp=%h", c, obs, exp_vec());
      end
      if (gnt1 && !changed) begin
        a1 = ~a1; b1 = ~b1; sel1 = ~sel1; cin1 = ~cin1;
        changed = 1;
      end
      if (ack1) begin
        seen = 1;
        checks++;
        if (result !== 9'(exp_r)) begin
          failures++;
          $display("FAIL isolation_result obs=%h exp=%h", result, 9'(exp_r));
        end
        req1 = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL isolation_ack obs=0 exp=1");
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    do_reset();
    sel0 = 3'b000; a0 = 8'hFF; b0 = 8'hFF; cin0 = 1'b1;
    req0 = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack0 || ack1) acks++;
      checks++;
      if (obs !== 14'h0) begin
        failures++;
        $display("FAIL reset_mid cyc%0d obs=%h exp=%h", c, obs, 14'h0);
      end
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL reset_mid_ack obs=%0d exp=0", acks);
    end
    rand_port0(); rand_port1();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_tie gnt0=%b gnt1=%b exp gnt0=1 gnt1=0", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_early_drop();
    int acks = 0;
    do_reset();
    rand_port0();
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ack0) acks++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL early_drop cyc%0d obs=%h exp=%h", c, obs, exp_vec());
      end
    end
    checks++;
    if (acks != 1 || busy !== 1'b0 || gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL early_drop_ack acks=%0d busy=%b gnt0=%b exp acks=1 busy=0 gnt0=0", acks, busy, gnt0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0 = ($urandom_range(0, 9) < 6);
      req1 = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 49) == 0);
      rand_port0(); rand_port1();
      tick();
      checks++;
      if (obs !== exp_vec() || (gnt0 && gnt1)) begin
        failures++;
        $display("FAIL random cyc%0d obs=%h exp=%h", c, obs, exp_vec());
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_tie();
    test_isolation();
    test_reset_mid();
    test_early_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one nbit_ALU between two requesters (port 0, port 1) using a req/ack handshake and round-robin arbitration.
- Captures the winner's operands, runs one ALU op, and registers the (n+1)-bit result.
- Returns the result with a one-cycle ack pulse to the granted requester.
- Sits between requester logic and the ALU-plus-register datapath; replaces direct wiring of a single source to the ALU.

Parameters:
n, 8, operand width; result width is n+1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req0  input  1  port 0 request; level, held with operands stable until ack0
sel0  input  3  port 0 ALU select, passed to nbit_ALU uninterpreted
a0  input  n  port 0 operand a (ALU r2)
b0  input  n  port 0 operand b (ALU r3)
cin0  input  1  port 0 carry-in
req1  input  1  port 1 request
sel1  input  3  port 1 ALU select
a1  input  n  port 1 operand a
b1  input  n  port 1 operand b
cin1  input  1  port 1 carry-in
gnt0  output  1  port 0 owns the ALU (EXEC and RESP)
gnt1  output  1  port 1 owns the ALU (EXEC and RESP)
ack0  output  1  one-cycle pulse; result valid for port 0
ack1  output  1  one-cycle pulse; result valid for port 1
result  output  n+1  last registered ALU output; holds until next op completes
busy  output  1  high in EXEC or RESP

Behaviour:
- Interface (decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; gnt0=gnt1=0; ack0=ack1=0; busy=0; result=0; operand/sel/cin capture registers=0; rr pointer=0, so port 0 has priority first.
- All outputs are registered; no combinational path from req to any output.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both reqs: grant the port selected by the rr pointer.
  - On grant: capture that port's sel/a/b/cin into internal registers, set the gnt bit, go to EXEC.
  - Then set the rr pointer to the other port, so after a grant to port k, port 1-k wins the next tie.
- EXEC:
  - nbit_ALU is driven only from the capture registers; input port changes have no effect.
  - At the clock edge, result <= ALU output; go to RESP.
- RESP:
  - The granted port's ack is high for exactly this cycle; the gnt bit stays high.
  - At the clock edge, clear gnt and ack and go to IDLE.
  - Reqs are ignored during EXEC and RESP.
- Latency: req sampled at edge T0 → gnt and busy high after T0 → result updated and ack high after T1 → IDLE after T2.
- Throughput: one op per 3 cycles.
- A requester holding req high through ack issues a new back-to-back request. It is re-arbitrated in IDLE at T2 and loses to a pending other port.
- Dropping req during EXEC or RESP does not abort the op; ack is still produced.
- Width: result is the full n+1-bit nbit_ALU output (MSB = carry/extra bit as defined by the ALU); no truncation or sign extension.
- result persists unchanged in IDLE and during the next EXEC; it changes only at the EXEC→RESP edge or on reset.
- Reset mid-operation, in any state: abort with no ack for the aborted op, result=0, rr pointer=0.
- rst has priority over all transitions.
- gnt0 and gnt1 are never both high; ack0 and ack1 are never both high; ackX implies gntX.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and the port-index constants.
- ALU select codes are not redefined here; they belong to nbit_ALU.
- Sub-module: the existing nbit_ALU (#(.n(n))), instantiated once.
- Arbitration, capture and FSM live in alu_rr_arbiter; no further sub-modules.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no reqs → all outputs 0 for 10 cycles; busy=0.
- Single request: req0=1, sel0=3'b000, a0=8'h0F, b0=8'h01, cin0=0, held until ack0 → gnt0 one cycle after sampling; ack0 pulses exactly once two cycles after sampling; result equals the nbit_ALU reference-model value for those inputs; gnt1=ack1=0 throughout.
- Simultaneous requests: req0=req1=1 held continuously after reset → grants alternate 0,1,0,1. Each ack has a 3-cycle spacing, and each result matches the model for that port's operands.
- Operand isolation: after gnt1 rises, change a1/b1/sel1 to different values → result still matches the captured operands.
- Reset mid-op: assert rst during EXEC → no ack is ever produced for that op; result=0. The first post-reset tie grants port 0.
- Early drop: req0 deasserted during EXEC → ack0 still pulses once; FSM returns to IDLE with no re-grant.
